// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider (signed/unsigned) with start/busy/done handshake.
// Optional DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             signed_reg;
  logic [WIDTH-1:0] dvd_reg, dvs_reg, rem_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             div_zero_reg, overflow_reg;

  logic             accept, a_neg, b_neg, div_zero, early_out, is_overflow, borrow;
  logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
  logic [WIDTH:0]   shifted, diff;

  assign accept   = start && (state_reg == IDLE || state_reg == DONE);
  assign a_neg    = signed_reg && a_reg[WIDTH-1];
  assign b_neg    = signed_reg && b_reg[WIDTH-1];
  assign mag_a    = a_neg ? -a_reg : a_reg;
  assign mag_b    = b_neg ? -b_reg : b_reg;
  assign div_zero = (b_reg == '0);
  assign is_overflow = signed_reg && (a_reg == {1'b1, {(WIDTH-1){1'b0}}}) && (b_reg == '1);

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (mag_a < mag_b);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step: quotient bits shift into dvd_reg as the dividend shifts out.
  assign shifted = {rem_reg, dvd_reg[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_reg};
  assign borrow  = diff[WIDTH];

  assign q_fix = (a_neg ^ b_neg) ? -dvd_reg : dvd_reg;
  assign r_fix = a_neg ? -rem_reg : rem_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = PREP;
      PREP: begin
        if (div_zero)       state_next = DONE;
        else if (early_out) state_next = FIX;
        else                state_next = ITER;
      end
      ITER: if (cnt_reg == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = start ? PREP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg         <= '0;
      b_reg         <= '0;
      signed_reg    <= 1'b0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (accept) begin
        a_reg      <= A;
        b_reg      <= B;
        signed_reg <= Signed;
      end
      case (state_reg)
        PREP: begin
          dvs_reg <= mag_b;
          cnt_reg <= CW'(WIDTH);
          if (div_zero) begin
            quotient_reg  <= '1;
            remainder_reg <= a_reg;
            div_zero_reg  <= 1'b1;
            overflow_reg  <= 1'b0;
          end else if (early_out) begin
            dvd_reg <= '0;
            rem_reg <= mag_a;
          end else begin
            dvd_reg <= mag_a;
            rem_reg <= '0;
          end
        end
        ITER: begin
          rem_reg <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          dvd_reg <= {dvd_reg[WIDTH-2:0], ~borrow};
          cnt_reg <= cnt_reg - CW'(1);
        end
        FIX: begin
          quotient_reg  <= q_fix;
          remainder_reg <= r_fix;
          div_zero_reg  <= 1'b0;
          overflow_reg  <= is_overflow;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg == PREP) || (state_reg == ITER) || (state_reg == FIX);
  assign done      = (state_reg == DONE);
  assign Quotient  = quotient_reg;
  assign Remainder = remainder_reg;
  assign DivZero   = div_zero_reg;
  assign Overflow  = overflow_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: scoreboard of expected results and latencies,
// checked with immediate assertions when done is observed.
module tb_div_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, Signed;
  logic [W-1:0] A, B;
  logic         busy, done, DivZero, Overflow;
  logic [W-1:0] Quotient, Remainder;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] last_q, last_r;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Signed(Signed),
    .busy(busy), .done(done), .Quotient(Quotient), .Remainder(Remainder),
    .DivZero(DivZero), .Overflow(Overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit arithmetic truncates toward zero, remainder takes dividend sign.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa, sb, qq, rr, ma, mb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.ov = 1'b0; e.lat = 2;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      e.q  = qq[W-1:0];
      e.r  = rr[W-1:0];
      e.dz = 1'b0;
      e.ov = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
      e.lat = (ma < mb) ? 3 : W + 3;
`else
      e.lat = (ma < mb) ? W + 3 : W + 3;
`endif
    end
    return e;
  endfunction

  // Drives start for one accepting edge, then follows the operation to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit noise);
    exp_t e;
    int   n, bc;
    bit   seen;
    sb_q.push_back(model(a, b, s));
    A = a; B = b; Signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; bc = 0; seen = 1'b0;
    check("hold_q_on_accept", 64'(Quotient), 64'(last_q));
    check("hold_r_on_accept", 64'(Remainder), 64'(last_r));
    while (n <= 100) begin
      if (done) begin
        check("done_not_busy", 64'(busy), 64'(0));
        seen = 1'b1;
        break;
      end
      if (busy) bc++;
      if (noise) begin
        A = $urandom; B = $urandom; Signed = 1'($urandom); start = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    e = sb_q.pop_front();
    check("done_seen", 64'(seen), 64'(1));
    check("latency", 64'(n), 64'(e.lat));
    check("busy_cycles", 64'(bc), 64'(e.lat - 1));
    check("quotient", 64'(Quotient), 64'(e.q));
    check("remainder", 64'(Remainder), 64'(e.r));
    check("divzero", 64'(DivZero), 64'(e.dz));
    check("overflow", 64'(Overflow), 64'(e.ov));
    $display("op a=%h b=%h s=%0d -> q=%h r=%h dz=%0d ov=%0d lat=%0d",
             a, b, s, Quotient, Remainder, DivZero, Overflow, n);
    last_q = Quotient;
    last_r = Remainder;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_hold_q", 64'(Quotient), 64'(last_q));
    check("idle_hold_r", 64'(Remainder), 64'(last_r));
  endtask

  initial begin
    int dcount;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; Signed = 1'b0;
    last_q = '0; last_r = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_q", 64'(Quotient), 64'(0));
    check("rst_r", 64'(Remainder), 64'(0));
    check("rst_dz", 64'(DivZero), 64'(0));
    check("rst_ov", 64'(Overflow), 64'(0));

    run_op(32'd100, 32'd7, 1'b0, 1'b0);
    check("100div7_q_const", 64'(Quotient), 64'(14));
    idle_check();
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    check("neg7div2_q_const", 64'(Quotient), 64'(32'hFFFF_FFFD));
    idle_check();
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle_check();
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("ovf_const", 64'(Overflow), 64'(1));
    idle_check();
    run_op(32'd1234, 32'd0, 1'b0, 1'b0);
    idle_check();
    run_op(32'h8000_0000, 32'd0, 1'b1, 1'b0);
    idle_check();
    run_op(32'd5, 32'd9, 1'b0, 1'b0);
    idle_check();
    run_op(32'hFFFF_FFFB, 32'd9, 1'b1, 1'b0);
    idle_check();
    run_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 1'b1);
    idle_check();
    run_op(32'h8765_4321, 32'hFFFF_FF03, 1'b1, 1'b1);
    idle_check();

    // Back-to-back: start is held through each DONE cycle.
    run_op(32'd1000, 32'd33, 1'b0, 1'b0);
    run_op(32'hFFFF_FC18, 32'd33, 1'b1, 1'b0);
    run_op(32'd77, 32'd0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle_check();

    for (int i = 0; i < 4; i++) begin
      run_op($urandom, $urandom_range(1, 100000), 1'(i), 1'b0);
    end
    idle_check();

    // Abort on the 10th ITER cycle.
    A = 32'd100; B = 32'd7; Signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_q", 64'(Quotient), 64'(0));
    check("abort_r", 64'(Remainder), 64'(0));
    check("abort_dz", 64'(DivZero), 64'(0));
    check("abort_ov", 64'(Overflow), 64'(0));
    last_q = '0; last_r = '0;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'(0));
    $display("abort: reset mid-ITER, done pulses afterwards=%0d", dcount);
    run_op(32'd100, 32'd7, 1'b0, 1'b0);
    idle_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; iteration count equals WIDTH.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a division; sampled only when ready.
REQ-005 SHALL have port A  input  WIDTH  dividend; latched on the accepting edge.
REQ-006 SHALL have port B  input  WIDTH  divisor; latched on the accepting edge.
REQ-007 SHALL have port Signed  input  1  1 = two's-complement operands, 0 = unsigned; latched on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse when results become valid.
REQ-010 SHALL have port Quotient  output  WIDTH  result quotient (LO).
REQ-011 SHALL have port Remainder  output  WIDTH  result remainder (HI).
REQ-012 SHALL have port DivZero  output  1  set with done when the latched B == 0.
REQ-013 SHALL have port Overflow  output  1  set with done for signed most-negative / -1.

Function
REQ-014 SHALL implement states IDLE, PREP, ITER, FIX, DONE.
REQ-015 SHALL treat the block as ready in IDLE and DONE; start=1 on an edge in either state is accepted: operands are latched and the next state is PREP.
REQ-016 SHALL ignore start, A, B and Signed while busy; latched operands are the only inputs used.
REQ-017 SHALL drive busy=1 in PREP, ITER and FIX, and busy=0 in IDLE and DONE.
REQ-018 PREP SHALL form operand magnitudes (absolute values if Signed, raw values otherwise), clear the partial remainder, and load the iteration counter with WIDTH.
REQ-019 PREP with divisor 0 SHALL go to DONE with Quotient = all-ones, Remainder = latched A, DivZero=1, and Overflow=0; done SHALL occur 2 edges after acceptance.
REQ-020 ITER SHALL perform one restoring step per cycle: shift the partial remainder left by one and bring in the dividend MSB, subtract the divisor magnitude, keep the difference when it is non-negative (quotient bit 1), otherwise restore (quotient bit 0), and decrement the counter.
REQ-021 ITER SHALL go to FIX on the cycle in which the counter reaches 0, after exactly WIDTH ITER cycles.
REQ-022 FIX SHALL negate the quotient if Signed and sign(A) differs from sign(B), negate the remainder if Signed and A is negative, and register the results; the next state is DONE.
REQ-023 DONE SHALL assert done for exactly one cycle; the next state is IDLE, or PREP if start is accepted in that cycle.
REQ-024 Normal latency SHALL be WIDTH+3 edges from the accepting edge to the cycle in which done is high (35 for WIDTH=32).
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL produce Quotient=0x80000000, Remainder=0, Overflow=1 (wrap-around result).
REQ-026 Quotient, Remainder, DivZero and Overflow SHALL hold their values from DONE until the FIX or DONE state of the next accepted operation; they SHALL not be cleared on acceptance.
REQ-027 done SHALL never be asserted in the same cycle as busy.

Reset
REQ-028 reset=1 on a rising edge SHALL force IDLE regardless of state, including mid-ITER; it takes priority over start.
REQ-029 After reset, busy=0, done=0, Quotient=0, Remainder=0, DivZero=0, Overflow=0, and the counter is 0.
REQ-030 An operation aborted by reset SHALL produce no done pulse.

Configuration
REQ-031 Macro DIV_EARLY_OUT_EN defined: PREP SHALL go directly to FIX when the dividend magnitude is less than the divisor magnitude (divisor nonzero), with quotient magnitude 0 and remainder magnitude equal to the dividend magnitude; latency is 3 edges.
REQ-032 Macro DIV_EARLY_OUT_EN undefined: every nonzero-divisor operation SHALL take the full WIDTH+3 latency.

Verification
REQ-033 Unsigned 100/7, start for one cycle -> done 35 edges later, Quotient=14, Remainder=2, flags 0, busy high for 34 cycles.
REQ-034 Signed 0xFFFFFFF9 / 2 (-7/2) -> Quotient=0xFFFFFFFD, Remainder=0xFFFFFFFF; unsigned 0xFFFFFFF9/2 -> Quotient=0x7FFFFFFC, Remainder=1.
REQ-035 Signed 0x80000000 / 0xFFFFFFFF -> Overflow=1, Quotient=0x80000000, Remainder=0; any A/0 -> done 2 edges later, DivZero=1, Quotient=0xFFFFFFFF, Remainder=A.
REQ-036 reset asserted on the 10th ITER cycle -> busy=0 and all outputs 0 on the next cycle; no done pulse; a new start afterwards completes normally.
REQ-037 start pulses and operand changes during busy are ignored and results are unaffected; start held high through DONE begins a back-to-back operation with done 35 edges after that DONE cycle.
REQ-038 With DIV_EARLY_OUT_EN defined, 5/9 unsigned -> done 3 edges after acceptance, Quotient=0, Remainder=5; without the macro, the same stimulus gives done after 35 edges with the same results.
